led_pwm_dimmer: RTL and testbench

LED_PWM_DIMMER -- requirements
Module: led_pwm_dimmer

---
 rtl/led_pwm_dimmer.sv | 180 ++++++++++++++++++
 tb/tb_led_pwm_dimmer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer
//
// Three-channel PWM dimmer sitting between the LED sequencer and the RGB pads.
// A prescaler divides clk into PWM ticks; 255 ticks form one PWM period.
// Each channel has an 8-bit brightness level that is fixed for a whole period
// and refreshed only at period end. The pad is on while the period counter is
// below the level, so level N gives N ticks of on-time per period.
//
// Optional feature (compile-time macro LED_PWM_FADE_EN):
//   defined   -> with fade_step != 0 each level walks toward its target by
//                fade_step per period end, stopping exactly on the target.
//   undefined -> level jumps straight to the target; fade_step is ignored.
//
// Ports
//   clk               system clock (12 MHz)
//   rst               synchronous active-high reset, overrides everything
//   enable            dimmer enable; low holds counters/levels at 0, outputs off
//   led_r/g/b_in      raw colour bits from the LED sequencer
//   duty_r/g/b        per-channel brightness, 0 = off, 255 = fully on
//   fade_step         level change per period when fading (0 = no fade)
//   led_r/g/b         registered PWM drive to the pads
//   pwm_sync          one-clk pulse on the first clk of each PWM period

module led_pwm_dimmer #(
  parameter logic [13:0] TERMINAL_CNT_TICK = 14'd46
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       led_r_in,
  input  logic       led_g_in,
  input  logic       led_b_in,
  input  logic [7:0] duty_r,
  input  logic [7:0] duty_g,
  input  logic [7:0] duty_b,
  input  logic [3:0] fade_step,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       pwm_sync
);

  localparam logic [7:0] PeriodLast = 8'd254;

  // Timing chain
  logic [13:0] presc_q, presc_d;
  logic [7:0]  period_q, period_d;
  logic        tick;
  logic        period_end;

  // Channel state, index 0 = red, 1 = green, 2 = blue
  logic            enable_q;
  logic            load_shadow;
  logic [2:0]      chan_in;
  logic [2:0]      chan_in_q;
  logic [2:0][7:0] duty;
  logic [2:0][7:0] shadow_q, shadow_d;
  logic [2:0][7:0] target;
  logic [2:0][7:0] level_q, level_d;

  // Output registers
  logic [2:0] led_q, led_d;
  logic       sync_q, sync_d;

  assign chan_in = {led_b_in, led_g_in, led_r_in};
  assign duty    = {duty_b, duty_g, duty_r};

`ifdef LED_PWM_FADE_EN
  // One fade step from cur toward tgt. Arithmetic is 9 bits wide so a large
  // step near 0 or 255 cannot wrap; the result is clamped onto the target.
  function automatic logic [7:0] fade_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [3:0] step);
    logic [8:0] up;
    logic [8:0] down;
    logic [7:0] res;
    up   = {1'b0, cur} + {5'd0, step};
    down = {1'b0, cur} - {5'd0, step};
    if (cur < tgt) begin
      res = (up >= {1'b0, tgt}) ? tgt : up[7:0];
    end else if (cur > tgt) begin
      // down[8] set means the subtraction went below zero
      res = (down[8] || (down[7:0] <= tgt)) ? tgt : down[7:0];
    end else begin
      res = cur;
    end
    return res;
  endfunction
`else
  // Port kept for pin compatibility with the fading build.
  logic unused_fade_step;
  assign unused_fade_step = ^fade_step;
`endif

  // Prescaler and period counter. Both sit at zero while disabled so the
  // first period after enable rises is a full, aligned period.
  always_comb begin
    presc_d    = presc_q;
    period_d   = period_q;
    tick       = enable && (presc_q == TERMINAL_CNT_TICK);
    period_end = tick && (period_q == PeriodLast);
    if (!enable) begin
      presc_d  = '0;
      period_d = '0;
    end else begin
      presc_d = tick ? 14'd0 : presc_q + 14'd1;
      if (tick) begin
        period_d = (period_q == PeriodLast) ? 8'd0 : period_q + 8'd1;
      end
    end
  end

  // Duty shadows are captured on the first enabled clk and at every period
  // end. Targets are formed from the value being captured, so a duty written
  // mid-period lands in the very next period and never in the current one.
  always_comb begin
    load_shadow = enable && (!enable_q || period_end);
    shadow_d    = load_shadow ? duty : shadow_q;
    for (int c = 0; c < 3; c++) begin
      target[c] = chan_in_q[c] ? shadow_d[c] : 8'd0;
    end
  end

  // Levels change only at period end.
  always_comb begin
    level_d = level_q;
    if (!enable) begin
      level_d = '0;
    end else if (period_end) begin
      for (int c = 0; c < 3; c++) begin
`ifdef LED_PWM_FADE_EN
        if (fade_step == 4'd0) begin
          level_d[c] = target[c];
        end else begin
          level_d[c] = fade_toward(level_q[c], target[c], fade_step);
        end
`else
        level_d[c] = target[c];
`endif
      end
    end
  end

  // Compare result is registered: exactly one clk from counter/level to pad.
  always_comb begin
    led_d = '0;
    for (int c = 0; c < 3; c++) begin
      led_d[c] = enable && (period_q < level_q[c]);
    end
    sync_d = period_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      period_q  <= '0;
      enable_q  <= 1'b0;
      chan_in_q <= '0;
      shadow_q  <= '0;
      level_q   <= '0;
      led_q     <= '0;
      sync_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      period_q  <= period_d;
      enable_q  <= enable;
      chan_in_q <= chan_in;
      shadow_q  <= shadow_d;
      level_q   <= level_d;
      led_q     <= led_d;
      sync_q    <= sync_d;
    end
  end

  assign led_r    = led_q[0];
  assign led_g    = led_q[1];
  assign led_b    = led_q[2];
  assign pwm_sync = sync_q;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Self-checking bench for led_pwm_dimmer.
// The main instance uses a 5-clk tick so a PWM period is 1275 clk; a second
// instance keeps the default prescaler and checks the 11985-clk period.

module tb_led_pwm_dimmer;

  localparam logic [13:0] Term     = 14'd4;
  localparam int          TickClks = 5;
  localparam int          Period   = 255 * TickClks;
  localparam int          DefPeriod = 255 * 47;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       led_r_in, led_g_in, led_b_in;
  logic [7:0] duty_r, duty_g, duty_b;
  logic [3:0] fade_step;
  logic       led_r, led_g, led_b, pwm_sync;
  logic [2:0] leds;

  logic       rst_def;
  logic       en_def;
  logic       def_r, def_g, def_b, def_sync;
  bit         def_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int hi[3];
  int last_hi[3];
  int sync_err;

  typedef struct {
    logic [2:0] ins;   // {b, g, r}
    logic [7:0] dr, dg, db;
    int         er, eg, eb;  // expected on-ticks per period
  } vec_t;

  vec_t vecs[4];

  assign leds = {led_b, led_g, led_r};

  led_pwm_dimmer #(.TERMINAL_CNT_TICK(Term)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .led_r_in (led_r_in),
    .led_g_in (led_g_in),
    .led_b_in (led_b_in),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .fade_step(fade_step),
    .led_r    (led_r),
    .led_g    (led_g),
    .led_b    (led_b),
    .pwm_sync (pwm_sync)
  );

  led_pwm_dimmer dut_def (
    .clk      (clk),
    .rst      (rst_def),
    .enable   (en_def),
    .led_r_in (led_r_in),
    .led_g_in (led_g_in),
    .led_b_in (led_b_in),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .fade_step(fade_step),
    .led_r    (def_r),
    .led_g    (def_g),
    .led_b    (def_b),
    .pwm_sync (def_sync)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    {led_b_in, led_g_in, led_r_in} = v.ins;
    duty_r = v.dr;
    duty_g = v.dg;
    duty_b = v.db;
  endtask

  // Called right after a pwm_sync sample; records one full period of pad
  // activity and ends on the next pwm_sync sample. At sample chg_at the blue
  // inputs are rewritten to exercise mid-period changes.
  task automatic count_period(input int chg_at, input logic new_in_b,
                              input logic [7:0] new_duty_b);
    for (int c = 0; c < 3; c++) begin
      hi[c]      = 0;
      last_hi[c] = 0;
    end
    sync_err = 0;
    for (int i = 1; i <= Period; i++) begin
      step();
      for (int c = 0; c < 3; c++) begin
        if (leds[c] === 1'b1) begin
          hi[c]++;
          last_hi[c] = i;
        end
      end
      if (i == Period) begin
        if (pwm_sync !== 1'b1) sync_err++;
      end else if (pwm_sync !== 1'b0) begin
        sync_err++;
      end
      if (i == chg_at) begin
        led_b_in = new_in_b;
        duty_b   = new_duty_b;
      end
    end
  endtask

  // On-time must match and must be one run starting at the period's first clk.
  task automatic check_period(input string name, input int er, input int eg, input int eb);
    int want[3];
    want = '{er, eg, eb};
    for (int c = 0; c < 3; c++) begin
      check_int($sformatf("%s_ch%0d_on", name, c), hi[c], want[c] * TickClks);
      check_int($sformatf("%s_ch%0d_last", name, c), last_hi[c], want[c] * TickClks);
    end
    check_int({name, "_sync"}, sync_err, 0);
  endtask

  task automatic wait_first_sync(output int steps, output int lit);
    steps = 0;
    lit   = 0;
    do begin
      step();
      steps++;
      if (leds !== 3'b000) lit++;
    end while (pwm_sync !== 1'b1 && steps < Period + 50);
  endtask

  // Default-parameter instance: first pulse and period length at 47 clk/tick.
  initial begin : default_param
    int n;
    rst_def = 1'b1;
    en_def  = 1'b1;
    repeat (2) step();
    rst_def = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (def_sync !== 1'b1 && n < DefPeriod + 50);
    check_int("default_first_sync", n, DefPeriod);
    n = 0;
    do begin
      step();
      n++;
    end while (def_sync !== 1'b1 && n < DefPeriod + 50);
    check_int("default_period", n, DefPeriod);
    def_done = 1'b1;
  end

  initial begin : main
    int steps;
    int lit;

    vecs[0] = '{ins: 3'b111, dr: 8'd128, dg: 8'd0,   db: 8'd255, er: 128, eg: 0,   eb: 255};
    vecs[1] = '{ins: 3'b011, dr: 8'd1,   dg: 8'd255, db: 8'd77,  er: 1,   eg: 255, eb: 0};
    vecs[2] = '{ins: 3'b110, dr: 8'd200, dg: 8'd254, db: 8'd64,  er: 0,   eg: 254, eb: 64};
    vecs[3] = '{ins: 3'b101, dr: 8'd255, dg: 8'd9,   db: 8'd0,   er: 255, eg: 0,   eb: 0};

    rst       = 1'b1;
    enable    = 1'b1;
    led_r_in  = 1'b1;
    led_g_in  = 1'b1;
    led_b_in  = 1'b1;
    duty_r    = 8'd255;
    duty_g    = 8'd255;
    duty_b    = 8'd255;
    fade_step = 4'd0;
    repeat (3) step();
    check_bit("reset_led_r", led_r, 1'b0);
    check_bit("reset_led_g", led_g, 1'b0);
    check_bit("reset_led_b", led_b, 1'b0);
    check_bit("reset_sync", pwm_sync, 1'b0);

    apply(vecs[0]);
    step();
    rst = 1'b0;
    wait_first_sync(steps, lit);
    check_int("first_sync_delay", steps, Period);
    check_int("first_period_dark", lit, 0);

    // Table: the next row is written at the start of the period that
    // measures the current one.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) apply(vecs[i + 1]);
      count_period(-1, 1'b0, 8'd0);
      check_period($sformatf("vec%0d", i), vecs[i].er, vecs[i].eg, vecs[i].eb);
    end

    // Mid-period duty and colour-bit changes wait for the next period end.
    {led_b_in, led_g_in, led_r_in} = 3'b100;
    duty_r = 8'd0;
    duty_g = 8'd0;
    duty_b = 8'd64;
    count_period(-1, 1'b0, 8'd0);
    check_period("hold_vec3", 255, 0, 0);
    count_period(100 * TickClks, 1'b1, 8'd200);
    check_period("duty_chg_cur", 0, 0, 64);
    count_period(100 * TickClks, 1'b0, 8'd200);
    check_period("duty_chg_next", 0, 0, 200);
    count_period(-1, 1'b0, 8'd200);
    check_period("in_b_off", 0, 0, 0);

    // Enable dropped mid-period, then re-enabled with a new duty.
    led_r_in = 1'b1;
    duty_r   = 8'd255;
    count_period(-1, 1'b0, 8'd200);
    check_period("pre_disable", 0, 0, 0);
    repeat (300) step();
    check_bit("on_before_drop", led_r, 1'b1);
    enable = 1'b0;
    step();
    check_bit("dis_led_r", led_r, 1'b0);
    check_bit("dis_led_g", led_g, 1'b0);
    check_bit("dis_led_b", led_b, 1'b0);
    check_bit("dis_sync", pwm_sync, 1'b0);
    lit = 0;
    repeat (20) begin
      step();
      if (leds !== 3'b000 || pwm_sync !== 1'b0) lit++;
    end
    check_int("dis_hold_dark", lit, 0);
    duty_r = 8'd40;
    enable = 1'b1;
    wait_first_sync(steps, lit);
    check_int("reen_sync_delay", steps, Period);
    check_int("reen_first_dark", lit, 0);
    count_period(-1, 1'b0, 8'd200);
    check_period("reen_duty", 40, 0, 0);

    // Reset mid-period with a lit channel.
    duty_r = 8'd100;
    count_period(-1, 1'b0, 8'd200);
    check_period("pre_reset", 40, 0, 0);
    repeat (200) step();
    check_bit("on_before_reset", led_r, 1'b1);
    rst = 1'b1;
    step();
    check_bit("rst_led_r", led_r, 1'b0);
    check_bit("rst_led_g", led_g, 1'b0);
    check_bit("rst_led_b", led_b, 1'b0);
    check_bit("rst_sync", pwm_sync, 1'b0);
    lit = 0;
    repeat (3) begin
      step();
      if (leds !== 3'b000 || pwm_sync !== 1'b0) lit++;
    end
    check_int("rst_hold_dark", lit, 0);
    rst = 1'b0;
    wait_first_sync(steps, lit);
    check_int("post_rst_sync_delay", steps, Period);
    check_int("post_rst_first_dark", lit, 0);
    count_period(-1, 1'b0, 8'd200);
    check_period("post_rst", 100, 0, 0);

`ifdef LED_PWM_FADE_EN
    // Fade up 0 -> 25 in steps of 10, then back down to 0.
    led_r_in = 1'b0;
    count_period(-1, 1'b0, 8'd200);
    check_period("fade_pre", 100, 0, 0);
    fade_step = 4'd10;
    duty_r    = 8'd25;
    led_r_in  = 1'b1;
    count_period(-1, 1'b0, 8'd200);
    check_period("fade_up0", 0, 0, 0);
    count_period(-1, 1'b0, 8'd200);
    check_period("fade_up1", 10, 0, 0);
    count_period(-1, 1'b0, 8'd200);
    check_period("fade_up2", 20, 0, 0);
    led_r_in = 1'b0;
    count_period(-1, 1'b0, 8'd200);
    check_period("fade_up3", 25, 0, 0);
    count_period(-1, 1'b0, 8'd200);
    check_period("fade_dn1", 15, 0, 0);
    count_period(-1, 1'b0, 8'd200);
    check_period("fade_dn2", 5, 0, 0);
    count_period(-1, 1'b0, 8'd200);
    check_period("fade_dn3", 0, 0, 0);
`endif

    wait (def_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
